// File: rtl/fp_fma_arbiter.sv
// ============================================================================
// Module   : fp_fma_arbiter
// Brief    : Round-robin arbiter that shares one pipelined FP32 FMA unit
//            between NUM_REQ requesters. Each issued op is tagged with its
//            requester ID. The result is steered back to a per-requester
//            slot, which holds it until the requester acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_fma_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LAT        = 2,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // requester side
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic [NUM_REQ*32-1:0]         opa_i,
  input  logic [NUM_REQ*32-1:0]         opb_i,
  input  logic [NUM_REQ*32-1:0]         opc_i,
  input  logic [NUM_REQ*2-1:0]          op_i,
  input  logic [NUM_REQ*RND_WIDTH-1:0]  rnd_i,
  output logic [NUM_REQ*32-1:0]         res_o,
  output logic [NUM_REQ*STAT_WIDTH-1:0] status_o,
  output logic [NUM_REQ-1:0]            valid_o,
  input  logic [NUM_REQ-1:0]            ack_i,
  // FMA side
  output logic                          fma_en_o,
  output logic [31:0]                   fma_opa_o,
  output logic [31:0]                   fma_opb_o,
  output logic [31:0]                   fma_opc_o,
  output logic [1:0]                    fma_op_o,
  output logic [RND_WIDTH-1:0]          fma_rnd_o,
  input  logic [31:0]                   fma_res_i,
  input  logic [STAT_WIDTH-1:0]         fma_status_i,
  input  logic                          fma_valid_i
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Arbitration state
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    inflight_q;
  logic [NUM_REQ-1:0]    valid_q;
  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [IDW-1:0]        winner;
  int                    scan_idx;

  // Result slots
  logic [31:0]           res_q    [NUM_REQ];
  logic [STAT_WIDTH-1:0] status_q [NUM_REQ];

  // Tag pipe mirroring the FMA latency: stage LAT-1 is the tail
  logic [LAT-1:0]        tag_vld_q;
  logic [IDW-1:0]        tag_id_q [LAT];

  logic                  ret_fire;
  logic [IDW-1:0]        ret_id;

  // Busy is built only from registered state, so a freed slot becomes eligible one cycle after the ack
  assign eligible = req_i & ~(inflight_q | valid_q);

  // Scan from the round-robin pointer and pick the first eligible requester
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && eligible[scan_idx]) begin
        found  = 1'b1;
        winner = IDW'(scan_idx);
      end
    end
  end

  // Next pointer sits just past the winner and wraps at NUM_REQ
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (int'(winner) == NUM_REQ - 1) ptr_d = '0;
      else                             ptr_d = winner + IDW'(1);
    end
  end

  // Grant and operand mux. Everything is forced to zero when there is no grant or reset is asserted.
  always_comb begin
    gnt_o     = '0;
    fma_opa_o = '0;
    fma_opb_o = '0;
    fma_opc_o = '0;
    fma_op_o  = '0;
    fma_rnd_o = '0;
    if (found && !rst_i) begin
      gnt_o     = NUM_REQ'(1) << winner;
      fma_opa_o = opa_i[winner*32 +: 32];
      fma_opb_o = opb_i[winner*32 +: 32];
      fma_opc_o = opc_i[winner*32 +: 32];
      fma_op_o  = op_i[winner*2 +: 2];
      fma_rnd_o = rnd_i[winner*RND_WIDTH +: RND_WIDTH];
    end
  end

  assign fma_en_o = |gnt_o;

  // Returning results are matched to the tag that leaves the pipe tail; unmatched results are dropped
  assign ret_fire = fma_valid_i & tag_vld_q[LAT-1];
  assign ret_id   = tag_id_q[LAT-1];

  // Advance the pointer on each grant and push the issue tag down the latency pipe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
    end else begin
      if (fma_en_o) ptr_q <= ptr_d;
      tag_vld_q[0] <= fma_en_o;
      tag_id_q[0]  <= winner;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Slot bookkeeping: an issue marks the requester in flight, a return fills its slot, and an ack frees it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      valid_q    <= '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        res_q[r]    <= '0;
        status_q[r] <= '0;
      end
    end else begin
      valid_q <= valid_q & ~ack_i;
      if (fma_en_o) inflight_q[winner] <= 1'b1;
      if (ret_fire) begin
        inflight_q[ret_id] <= 1'b0;
        valid_q[ret_id]    <= 1'b1;
        res_q[ret_id]      <= fma_res_i;
        status_q[ret_id]   <= fma_status_i;
      end
    end
  end

  assign valid_o = valid_q;

  generate
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_slot_out
      assign res_o[r*32 +: 32]                 = res_q[r];
      assign status_o[r*STAT_WIDTH +: STAT_WIDTH] = status_q[r];
    end
  endgenerate

  // Every tagged issue must see its FMA result exactly LAT cycles later
  a_return_on_time: assert property (@(posedge clk_i) disable iff (rst_i)
                                     tag_vld_q[LAT-1] |-> fma_valid_i);

endmodule

`default_nettype wire

// File: tb/tb_fp_fma_arbiter.sv
// ============================================================================
// Module   : tb_fp_fma_arbiter
// Brief    : Scoreboard bench for fp_fma_arbiter using a fixed-latency FMA
//            stand-in and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_fma_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int RW  = 3;
  localparam int SW  = 5;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N-1:0]      gnt_o;
  logic [N*32-1:0]   opa_i = '0, opb_i = '0, opc_i = '0;
  logic [N*2-1:0]    op_i = '0;
  logic [N*RW-1:0]   rnd_i = '0;
  logic [N*32-1:0]   res_o;
  logic [N*SW-1:0]   status_o;
  logic [N-1:0]      valid_o;
  logic [N-1:0]      ack_i = '0;
  logic              fma_en_o;
  logic [31:0]       fma_opa_o, fma_opb_o, fma_opc_o;
  logic [1:0]        fma_op_o;
  logic [RW-1:0]     fma_rnd_o;
  logic [31:0]       fma_res_i;
  logic [SW-1:0]     fma_status_i;
  logic              fma_valid_i;

  fp_fma_arbiter #(.NUM_REQ(N), .LAT(LAT), .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o),
    .opa_i(opa_i), .opb_i(opb_i), .opc_i(opc_i), .op_i(op_i), .rnd_i(rnd_i),
    .res_o(res_o), .status_o(status_o), .valid_o(valid_o), .ack_i(ack_i),
    .fma_en_o(fma_en_o), .fma_opa_o(fma_opa_o), .fma_opb_o(fma_opb_o),
    .fma_opc_o(fma_opc_o), .fma_op_o(fma_op_o), .fma_rnd_o(fma_rnd_o),
    .fma_res_i(fma_res_i), .fma_status_i(fma_status_i), .fma_valid_i(fma_valid_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // FMA stand-in: exact for the directed 2*3+1 vectors, otherwise a deterministic scramble
  function automatic logic [31:0] fma_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [1:0] op,
                                         input logic [RW-1:0] rnd);
    if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000) begin
      if (op == 2'b00) return 32'h40E00000;
      if (op == 2'b11) return 32'hC0E00000;
    end
    return (a * 32'h9E3779B1) ^ {b[24:0], b[31:25]} ^ ~c ^ {27'd0, op, rnd};
  endfunction

  // Fixed-latency FMA pipe. Reset deliberately does not clear it, so late results still emerge.
  logic [LAT-1:0] fp_vld = '0;
  logic [31:0]    fp_res [LAT];
  logic [SW-1:0]  fp_st  [LAT];
  always @(posedge clk_i) begin
    fp_vld[0] <= fma_en_o;
    fp_res[0] <= fma_fn(fma_opa_o, fma_opb_o, fma_opc_o, fma_op_o, fma_rnd_o);
    fp_st[0]  <= {fma_op_o, fma_rnd_o};
    for (int s = 1; s < LAT; s++) begin
      fp_vld[s] <= fp_vld[s-1];
      fp_res[s] <= fp_res[s-1];
      fp_st[s]  <= fp_st[s-1];
    end
  end
  assign fma_valid_i  = fp_vld[LAT-1];
  assign fma_res_i    = fp_res[LAT-1];
  assign fma_status_i = fp_st[LAT-1];

  // Reference model: a requester is free (-1) or owns a slot that becomes readable at cycle ready[r]
  int ready [N];
  int ptr;
  typedef struct {
    int          id;
    logic [31:0] res;
    logic [SW-1:0] st;
    int          cyc;
  } exp_t;
  exp_t exp_q [$];

  logic [31:0]   a_r [N], b_r [N], c_r [N];
  logic [1:0]    o_r [N];
  logic [RW-1:0] m_r [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    for (int r = 0; r < N; r++) begin
      a_r[r] = $urandom; b_r[r] = $urandom; c_r[r] = $urandom;
      o_r[r] = 2'($urandom); m_r[r] = RW'($urandom);
    end
  endtask

  // One clock of stimulus: drive, check the combinational issue, then advance the model
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] ack_mask);
    int w;
    int idx;
    logic [N-1:0] ack;
    @(posedge clk_i); #1;
    ack = '0;
    for (int r = 0; r < N; r++) begin
      if (ack_mask[r]) begin
        if (ready[r] >= 0 && cyc >= ready[r]) ack[r] = 1'b1;
        else                                  ack[r] = 1'($urandom);
      end
      opa_i[r*32 +: 32] = a_r[r];
      opb_i[r*32 +: 32] = b_r[r];
      opc_i[r*32 +: 32] = c_r[r];
      op_i[r*2 +: 2]    = o_r[r];
      rnd_i[r*RW +: RW] = m_r[r];
    end
    req_i = req;
    ack_i = ack;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (w < 0 && req[idx] && ready[idx] < 0) w = idx;
    end
    chk("gnt", 64'(gnt_o), (w < 0) ? 64'd0 : (64'd1 << w));
    chk("fma_en", 64'(fma_en_o), 64'(w >= 0));
    if (w >= 0) begin
      chk("fma_opa", 64'(fma_opa_o), 64'(a_r[w]));
      chk("fma_opb", 64'(fma_opb_o), 64'(b_r[w]));
      chk("fma_opc", 64'(fma_opc_o), 64'(c_r[w]));
      chk("fma_op_rnd", 64'({fma_op_o, fma_rnd_o}), 64'({o_r[w], m_r[w]}));
    end else begin
      chk("fma_idle", 64'({fma_opa_o, fma_op_o, fma_rnd_o}), 64'd0);
    end
    for (int r = 0; r < N; r++)
      if (ack[r] && ready[r] >= 0 && cyc >= ready[r]) ready[r] = -1;
    if (w >= 0) begin
      ptr = (w + 1) % N;
      ready[w] = cyc + LAT + 1;
      exp_q.push_back('{w, fma_fn(a_r[w], b_r[w], c_r[w], o_r[w], m_r[w]),
                        {o_r[w], m_r[w]}, cyc + LAT + 1});
    end
  endtask

  task automatic model_clear();
    ptr = 0;
    for (int r = 0; r < N; r++) ready[r] = -1;
    exp_q.delete();
  endtask

  // Pulse reset for one cycle with every requester asserting req, and check the cleared state
  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    req_i = '1;
    ack_i = '0;
    model_clear();
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_en", 64'(fma_en_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_res_lo", res_o[63:0], 64'd0);
    chk("rst_res_hi", res_o[127:64], 64'd0);
    chk("rst_status", 64'(status_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = '0;
  endtask

  task automatic drain();
    repeat (LAT + 4) step('0, '1);
  endtask

  // Monitor: whenever a slot turns valid, match it against the oldest expected result for that requester
  logic [N-1:0] seen = '0;
  initial begin
    int hit;
    forever begin
      @(negedge clk_i);
      for (int r = 0; r < N; r++) begin
        if (valid_o[r] && !seen[r]) begin
          seen[r] = 1'b1;
          hit = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (hit < 0 && exp_q[i].id == r) hit = i;
          if (hit < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: slot %0d valid with res %h, none expected (cycle %0d)",
                     r, res_o[r*32 +: 32], cyc);
          end else begin
            chk("result", 64'(res_o[r*32 +: 32]), 64'(exp_q[hit].res));
            chk("status", 64'(status_o[r*SW +: SW]), 64'(exp_q[hit].st));
            chk("latency", 64'(cyc), 64'(exp_q[hit].cyc));
            exp_q.delete(hit);
          end
        end else if (!valid_o[r]) begin
          seen[r] = 1'b0;
        end
      end
    end
  end

  initial begin
    model_clear();
    rand_ops();
    do_reset();

    // Directed 2*3+1 with op=00, then with op=11
    a_r[0] = 32'h40000000; b_r[0] = 32'h40400000; c_r[0] = 32'h3F800000;
    o_r[0] = 2'b00; m_r[0] = 3'd0;
    step(4'b0001, 4'b0000);
    drain();
    chk("t1_hold_res", 64'(res_o[31:0]), 64'h40E00000);
    chk("t1_acked", 64'(valid_o[0]), 64'd0);
    o_r[0] = 2'b11;
    step(4'b0001, 4'b0000);
    drain();
    chk("t2_hold_res", 64'(res_o[31:0]), 64'hC0E00000);

    // All requesters busy, with acks as results land
    rand_ops();
    repeat (16) begin rand_ops(); step(4'b1111, 4'b1111); end
    // Requester 1 withholds its ack, then releases it
    repeat (12) begin rand_ops(); step(4'b1111, 4'b1101); end
    repeat (8)  begin rand_ops(); step(4'b1111, 4'b1111); end
    drain();

    // Wrap-around: move the pointer to 3, then request 0 and 3 together
    step(4'b0100, 4'b1111);
    step(4'b1001, 4'b1111);
    step(4'b1001, 4'b1111);
    drain();

    // Reset with two ops in flight; the late results must be dropped
    step(4'b0001, 4'b0000);
    step(4'b0010, 4'b0000);
    do_reset();
    repeat (LAT + 2) step('0, '0);
    rand_ops();
    step(4'b1111, 4'b0000);
    drain();

    // Randomized traffic
    repeat (400) begin
      rand_ops();
      step(N'($urandom), N'($urandom));
    end
    drain();
    chk("all_delivered", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
